ring_counter_enc: RTL and testbench
===================================

Name: ring_counter_enc

Overview:
- Parametrised one-hot ring counter with a built-in binary encoder. It is the next generation of the 16-stage ring/coder pair.
- Adds the following over the previous pair: generic depth, asynchronous reset, count enable, up/down direction, synchronous index load, wrap strobe, and self-correction of illegal (non-one-hot) states.
- Used as a sequencer/phase generator. Downstream logic consumes either the one-hot vector Q or the binary index C.

Parameters:
- N, default 16: number of ring stages (hot positions). Legal range 2..256.
- W, default $clog2(N) (4 at N=16): width of the binary index C and of LOAD_IDX.

Ports:
- CLK, input, 1: clock. All state updates on posedge.
- RST, input, 1: asynchronous, active-high reset.
- EN, input, 1: advance the ring one position on this edge.
- DIR, input, 1: 0 = up (hot bit i -> i+1 mod N); 1 = down (i -> i-1 mod N).
- LOAD, input, 1: synchronous load of the hot position from LOAD_IDX.
- LOAD_IDX, input, W: position to load. Legal range 0..N-1.
- Q, output, N: one-hot ring state. Bit 0 is the first/home stage.
- C, output, W: binary index of the hot bit, combinational from Q.
- WRAP, output, 1: registered one-cycle strobe when the ring wraps.
- ERR, output, 1: registered one-cycle strobe on illegal state or illegal load index.

Behaviour:
- Reset (RST=1, asynchronous, any time, including mid-count or mid-load):
  - Q = only bit 0 set; C = 0; WRAP = 0; ERR = 0.
  - Held while RST=1. The first update occurs on the first posedge after RST deasserts.
- Priority at each posedge, highest first:
  1. LOAD
  2. illegal-state correction
  3. EN
  4. hold
- LOAD=1 with LOAD_IDX < N: Q = one-hot(LOAD_IDX); WRAP = 0; ERR = 0. EN and DIR are ignored this cycle.
- LOAD=1 with LOAD_IDX >= N (possible only when N is not a power of 2): Q = position 0; ERR = 1 for one cycle; WRAP = 0.
- Illegal state (Q all-zero or more than one bit set) with LOAD=0: Q = position 0 on the next edge; ERR = 1 for one cycle; WRAP = 0. EN is ignored.
- EN=1, DIR=0, hot bit at i: next hot bit at (i+1) mod N.
  - WRAP = 1 in the cycle after the N-1 -> 0 transition, i.e. while Q shows position 0.
- EN=1, DIR=1, hot bit at i: next hot bit at (i-1) mod N.
  - WRAP = 1 in the cycle after the 0 -> N-1 transition.
- EN=0 (and no load, no correction): Q holds; WRAP = 0; ERR = 0.
- Latency:
  - Q, WRAP and ERR update one clock after the qualifying inputs are sampled.
  - C follows Q with zero cycles of latency (pure OR-tree encode). It is therefore always consistent with Q in the same cycle.
- C on an illegal Q is the OR of the indices of all set bits. It is don't-care for checking; only ERR and the correction are checked.
- DIR may change on any cycle. It is sampled only when EN=1.
- WRAP and ERR are never asserted in the same cycle.

Decomposition:
- Shared package ring_pkg holds:
  - the clog2-based width helper;
  - the constant HOME_IDX = 0;
  - a function onehot_valid(vec) that returns 1 iff exactly one bit is set.
- One sub-module, onehot_encoder #(N, W):
  - N-bit one-hot in, W-bit index out;
  - generate-built OR trees, one per output bit (bit k of C = OR of Q[i] for all i with bit k of i set).
- The top level holds the ring register, the priority mux, the WRAP/ERR flops, and one onehot_encoder instance.

Test Plan (N=16 unless noted):
- Reset and up-count: assert RST, release, EN=1, DIR=0 for 17 edges.
  - Q steps bit 0 -> bit 15 -> bit 0; C goes 0,1,...,15,0.
  - WRAP = 1 only in the cycle where C returns to 0.
- Down-count wrap: from reset, EN=1, DIR=1.
  - First edge: Q bit 15, C = 15, WRAP = 1.
  - Next edge: C = 14, WRAP = 0.
- Load priority: LOAD=1, LOAD_IDX=9, EN=1, DIR=0 on one edge.
  - C = 9 (not 10); WRAP = 0.
  - Next edge with EN=1: C = 10.
- Illegal-state recovery: force Q = 16'h0011 then release; one edge with EN=1.
  - Q = bit 0, C = 0, ERR = 1 for exactly one cycle.
  - Repeat with Q = 16'h0000: same result.
- Non-power-of-2 depth (N=12, W=4):
  - LOAD_IDX=13 -> Q = bit 0, ERR = 1.
  - Up-count from 11 -> C = 0, WRAP = 1.
- Asynchronous reset mid-count: at C = 7, pulse RST between clock edges.
  - Q = bit 0 and C = 0 immediately, without waiting for a clock edge.
  - WRAP = 0 and ERR = 0.
  - Counting resumes at C = 1 on the first edge after release.

Source files
------------

// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared constants and helpers for the one-hot ring counter
package ring_pkg;

  localparam int MAX_N    = 256;
  localparam int HOME_IDX = 0;

  // A 2-stage ring still needs one index bit, where $clog2(2) alone is fine but $clog2(1) is not.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic onehot_valid(input logic [MAX_N-1:0] vec);
    return (vec != '0) && ((vec & (vec - MAX_N'(1))) == '0);
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// rtl/onehot_encoder.sv - one-hot to binary index encoder built from per-bit OR trees
module onehot_encoder #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] q,
  output logic [W-1:0] c
);

  // Bit k of the index collects every stage whose position has bit k set.
  function automatic logic [N-1:0] bit_mask(input int k);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) begin
      m[i] = ((i >> k) & 1) != 0;
    end
    return m;
  endfunction

  generate
    for (genvar k = 0; k < W; k++) begin : g_bit
      localparam logic [N-1:0] MASK = bit_mask(k);
      assign c[k] = |(q & MASK);
    end
  endgenerate

endmodule

// File: rtl/ring_counter_enc.sv
// rtl/ring_counter_enc.sv - one-hot ring counter with load, direction, wrap strobe and self-correction
module ring_counter_enc
  import ring_pkg::*;
#(
  parameter int N = 16,
  parameter int W = idx_width(N)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic         DIR,
  input  logic         LOAD,
  input  logic [W-1:0] LOAD_IDX,
  output logic [N-1:0] Q,
  output logic [W-1:0] C,
  output logic         WRAP,
  output logic         ERR
);

  localparam logic [N-1:0] HOME_VEC = N'(1) << HOME_IDX;
  localparam logic [W-1:0] TOP_IDX  = W'(N - 1);
  localparam logic [W-1:0] HOME_C   = W'(HOME_IDX);

  logic [N-1:0] ring_q;
  logic [N-1:0] ring_d;
  logic         wrap_d;
  logic         err_d;
  logic         legal;
  logic         load_ok;

  onehot_encoder #(
    .N(N),
    .W(W)
  ) u_enc (
    .q(ring_q),
    .c(C)
  );

  assign legal   = onehot_valid(MAX_N'(ring_q));
  assign load_ok = ({1'b0, LOAD_IDX} < (W + 1)'(N));

  // C is only trusted for the wrap decision once the ring is known to be one-hot.
  always_comb begin
    ring_d = ring_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (LOAD) begin
      if (load_ok) begin
        ring_d = N'(1) << LOAD_IDX;
      end else begin
        ring_d = HOME_VEC;
        err_d  = 1'b1;
      end
    end else if (!legal) begin
      ring_d = HOME_VEC;
      err_d  = 1'b1;
    end else if (EN) begin
      if (DIR) begin
        ring_d = {ring_q[0], ring_q[N-1:1]};
        wrap_d = (C == HOME_C);
      end else begin
        ring_d = {ring_q[N-2:0], ring_q[N-1]};
        wrap_d = (C == TOP_IDX);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ring_q <= HOME_VEC;
      WRAP   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      ring_q <= ring_d;
      WRAP   <= wrap_d;
      ERR    <= err_d;
    end
  end

  assign Q = ring_q;

endmodule

// File: tb/tb_ring_counter_enc.sv
// tb/tb_ring_counter_enc.sv - self-checking bench for ring_counter_enc at N=16 and N=12
module tb_ring_counter_enc;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic        en16, dir16, load16;
  logic [3:0]  idx16;
  logic [15:0] q16;
  logic [3:0]  c16;
  logic        wrap16, err16;
  logic        en12, dir12, load12;
  logic [3:0]  idx12;
  logic [11:0] q12;
  logic [3:0]  c12;
  logic        wrap12, err12;

  int errors = 0;
  int checks = 0;

  int pos16, pos12;
  bit ew16, ee16, ew12, ee12;

  ring_counter_enc #(.N(16), .W(4)) dut16 (
    .CLK(CLK), .RST(RST), .EN(en16), .DIR(dir16), .LOAD(load16), .LOAD_IDX(idx16),
    .Q(q16), .C(c16), .WRAP(wrap16), .ERR(err16)
  );

  ring_counter_enc #(.N(12), .W(4)) dut12 (
    .CLK(CLK), .RST(RST), .EN(en12), .DIR(dir12), .LOAD(load12), .LOAD_IDX(idx12),
    .Q(q12), .C(c12), .WRAP(wrap12), .ERR(err12)
  );

  // Position-level model: the ring is just an integer position modulo n.
  task automatic model(input int n, input int pos, input bit en, input bit dir, input bit load,
                       input int idx, output int npos, output bit wrap, output bit err);
    wrap = 1'b0;
    err  = 1'b0;
    npos = pos;
    if (load) begin
      if (idx < n) npos = idx;
      else begin
        npos = 0;
        err  = 1'b1;
      end
    end else if (en) begin
      if (dir) begin
        npos = (pos + n - 1) % n;
        wrap = (pos == 0);
      end else begin
        npos = (pos + 1) % n;
        wrap = (pos == n - 1);
      end
    end
  endtask

  task automatic tick();
    int n16, n12;
    bit w16, e16, w12, e12;
    model(16, pos16, en16, dir16, load16, int'(idx16), n16, w16, e16);
    model(12, pos12, en12, dir12, load12, int'(idx12), n12, w12, e12);
    @(posedge CLK);
    pos16 = n16; ew16 = w16; ee16 = e16;
    pos12 = n12; ew12 = w12; ee12 = e12;
    #1;
  endtask

  task automatic model_reset();
    pos16 = 0; pos12 = 0;
    ew16 = 0; ee16 = 0; ew12 = 0; ee12 = 0;
  endtask

  task automatic idle_inputs();
    en16 = 0; dir16 = 0; load16 = 0; idx16 = '0;
    en12 = 0; dir12 = 0; load12 = 0; idx12 = '0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    en16 = 1; en12 = 1;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (q16 !== 16'h0001) begin errors++; $display("FAIL reset_q16 got %h expected %h", q16, 16'h0001); end
    checks++; if (c16 !== 4'd0) begin errors++; $display("FAIL reset_c16 got %0d expected 0", c16); end
    checks++; if ({wrap16, err16} !== 2'b00) begin errors++; $display("FAIL reset_flags16 got %b expected 00", {wrap16, err16}); end
    checks++; if (q12 !== 12'h001) begin errors++; $display("FAIL reset_q12 got %h expected %h", q12, 12'h001); end
    RST = 1'b0;
    idle_inputs();
    model_reset();
  endtask

  task automatic test_up_count();
    logic [15:0] eq;
    en16 = 1; dir16 = 0;
    for (int i = 0; i < 17; i++) begin
      tick();
      eq = 16'(1) << pos16;
      checks++; if (q16 !== eq) begin errors++; $display("FAIL up_q step %0d got %h expected %h", i, q16, eq); end
      checks++; if (c16 !== 4'(pos16)) begin errors++; $display("FAIL up_c step %0d got %0d expected %0d", i, c16, pos16); end
      checks++; if (wrap16 !== ew16) begin errors++; $display("FAIL up_wrap step %0d got %b expected %b", i, wrap16, ew16); end
    end
    en16 = 0;
  endtask

  task automatic test_down_wrap();
    RST = 1'b1; #2; RST = 1'b0;
    model_reset();
    en16 = 1; dir16 = 1;
    tick();
    checks++; if (q16 !== 16'h8000) begin errors++; $display("FAIL down_q got %h expected 8000", q16); end
    checks++; if (c16 !== 4'd15) begin errors++; $display("FAIL down_c got %0d expected 15", c16); end
    checks++; if (wrap16 !== 1'b1) begin errors++; $display("FAIL down_wrap got %b expected 1", wrap16); end
    tick();
    checks++; if (c16 !== 4'd14) begin errors++; $display("FAIL down_c2 got %0d expected 14", c16); end
    checks++; if (wrap16 !== 1'b0) begin errors++; $display("FAIL down_wrap2 got %b expected 0", wrap16); end
    en16 = 0; dir16 = 0;
  endtask

  task automatic test_load_priority();
    load16 = 1; idx16 = 4'd9; en16 = 1; dir16 = 0;
    tick();
    checks++; if (c16 !== 4'd9) begin errors++; $display("FAIL load_c got %0d expected 9", c16); end
    checks++; if ({wrap16, err16} !== 2'b00) begin errors++; $display("FAIL load_flags got %b expected 00", {wrap16, err16}); end
    load16 = 0;
    tick();
    checks++; if (c16 !== 4'd10) begin errors++; $display("FAIL load_next_c got %0d expected 10", c16); end
    en16 = 0;
  endtask

  task automatic test_illegal_recovery();
    logic [15:0] pats [2];
    pats[0] = 16'h0011;
    pats[1] = 16'h0000;
    for (int p = 0; p < 2; p++) begin
      en16 = 1; dir16 = 0;
      force dut16.ring_q = pats[p];
      #1;
      release dut16.ring_q;
      @(posedge CLK); #1;
      checks++; if (q16 !== 16'h0001) begin errors++; $display("FAIL illegal_q pat %h got %h expected 0001", pats[p], q16); end
      checks++; if (c16 !== 4'd0) begin errors++; $display("FAIL illegal_c pat %h got %0d expected 0", pats[p], c16); end
      checks++; if ({err16, wrap16} !== 2'b10) begin errors++; $display("FAIL illegal_flags pat %h got %b expected 10", pats[p], {err16, wrap16}); end
      en16 = 0;
      @(posedge CLK); #1;
      checks++; if (err16 !== 1'b0) begin errors++; $display("FAIL illegal_err_once pat %h got %b expected 0", pats[p], err16); end
      checks++; if (q16 !== 16'h0001) begin errors++; $display("FAIL illegal_hold pat %h got %h expected 0001", pats[p], q16); end
    end
    pos16 = 0;
  endtask

  task automatic test_non_pow2();
    load12 = 1; idx12 = 4'd13;
    tick();
    checks++; if (q12 !== 12'h001) begin errors++; $display("FAIL np2_badload_q got %h expected 001", q12); end
    checks++; if ({err12, wrap12} !== 2'b10) begin errors++; $display("FAIL np2_badload_flags got %b expected 10", {err12, wrap12}); end
    idx12 = 4'd11;
    tick();
    checks++; if (c12 !== 4'd11 || err12 !== 1'b0) begin errors++; $display("FAIL np2_load11 got c=%0d err=%b expected c=11 err=0", c12, err12); end
    load12 = 0; en12 = 1; dir12 = 0;
    tick();
    checks++; if (c12 !== 4'd0 || q12 !== 12'h001) begin errors++; $display("FAIL np2_upwrap_c got c=%0d q=%h expected c=0 q=001", c12, q12); end
    checks++; if ({wrap12, err12} !== 2'b10) begin errors++; $display("FAIL np2_upwrap_flags got %b expected 10", {wrap12, err12}); end
    dir12 = 1;
    tick();
    checks++; if (c12 !== 4'd11 || wrap12 !== 1'b1) begin errors++; $display("FAIL np2_downwrap got c=%0d wrap=%b expected c=11 wrap=1", c12, wrap12); end
    en12 = 0; dir12 = 0;
  endtask

  task automatic test_async_reset();
    load16 = 1; idx16 = 4'd0;
    tick();
    load16 = 0; en16 = 1; dir16 = 0;
    repeat (7) tick();
    checks++; if (c16 !== 4'd7) begin errors++; $display("FAIL async_pre_c got %0d expected 7", c16); end
    #1 RST = 1'b1;
    #1;
    checks++; if (q16 !== 16'h0001 || c16 !== 4'd0) begin errors++; $display("FAIL async_imm got q=%h c=%0d expected q=0001 c=0", q16, c16); end
    checks++; if ({wrap16, err16} !== 2'b00) begin errors++; $display("FAIL async_flags got %b expected 00", {wrap16, err16}); end
    #1 RST = 1'b0;
    model_reset();
    tick();
    checks++; if (c16 !== 4'd1) begin errors++; $display("FAIL async_resume got %0d expected 1", c16); end
    en16 = 0;
  endtask

  task automatic test_random();
    logic [15:0] eq16;
    logic [11:0] eq12;
    for (int i = 0; i < 400; i++) begin
      en16 = 1'($urandom); dir16 = 1'($urandom); load16 = ($urandom_range(0, 7) == 0);
      idx16 = 4'($urandom_range(0, 15));
      en12 = 1'($urandom); dir12 = 1'($urandom); load12 = ($urandom_range(0, 5) == 0);
      idx12 = 4'($urandom_range(0, 15));
      tick();
      eq16 = 16'(1) << pos16;
      eq12 = 12'(1) << pos12;
      checks++; if (q16 !== eq16 || c16 !== 4'(pos16)) begin errors++; $display("FAIL rnd16_state iter %0d got q=%h c=%0d expected q=%h c=%0d", i, q16, c16, eq16, pos16); end
      checks++; if ({wrap16, err16} !== {ew16, ee16}) begin errors++; $display("FAIL rnd16_flags iter %0d got %b expected %b", i, {wrap16, err16}, {ew16, ee16}); end
      checks++; if (q12 !== eq12 || c12 !== 4'(pos12)) begin errors++; $display("FAIL rnd12_state iter %0d got q=%h c=%0d expected q=%h c=%0d", i, q12, c12, eq12, pos12); end
      checks++; if ({wrap12, err12} !== {ew12, ee12}) begin errors++; $display("FAIL rnd12_flags iter %0d got %b expected %b", i, {wrap12, err12}, {ew12, ee12}); end
    end
    idle_inputs();
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_up_count();
    test_down_wrap();
    test_load_priority();
    test_illegal_recovery();
    test_non_pow2();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
